seq_detect_stream_ctrl: RTL

Controller that feeds a word-oriented input stream, one bit per cycle and MSB first, into a programmable Moore-style bit-pattern detector. It accepts parallel words over a valid/ready handshake and serializes them. It runs the detection in overlap or non-overlap mode and counts matches across the whole stream, including matches that span word boundaries. It sits between a word-wide producer and the status/interrupt logic that consumes match events.

---
 rtl/seq_detect_stream_ctrl_if.sv | 32 +++
 rtl/seq_detect_stream_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seq_detect_stream_ctrl_if.sv
// Word-stream handshake, pattern configuration and match-status bundle
// between a word producer and seq_detect_stream_ctrl.
interface seq_detect_stream_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PAT_W  = 4,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  logic              start;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [LEN_W-1:0]  cfg_len;
  logic              cfg_overlap;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              busy;
  logic              match_pulse;
  logic [CNT_W-1:0]  match_count;
  logic              done;

  modport master (
    output start, cfg_pattern, cfg_len, cfg_overlap, in_data, in_valid, in_last,
    input  in_ready, busy, match_pulse, match_count, done
  );

  modport slave (
    input  start, cfg_pattern, cfg_len, cfg_overlap, in_data, in_valid, in_last,
    output in_ready, busy, match_pulse, match_count, done
  );
endinterface

// File: rtl/seq_detect_stream_ctrl.sv
// Serializes accepted words MSB first into a programmable bit-pattern
// detector; counts overlapping or non-overlapping matches across the stream.
module seq_detect_stream_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PAT_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_detect_stream_ctrl_if.slave bus
);
  localparam int unsigned LEN_W  = $clog2(PAT_W + 1);
  localparam int unsigned BCNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [LEN_W-1:0]  hval_q, hval_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ovl_q, ovl_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [PAT_W-1:0]  hist_sh;
  logic [LEN_W-1:0]  hval_inc;
  logic [PAT_W-1:0]  len_mask;
  logic              hit;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      last_q  <= 1'b0;
      bcnt_q  <= '0;
      hist_q  <= '0;
      hval_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      match_q <= 1'b0;
      count_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      hist_q  <= hist_d;
      hval_q  <= hval_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      match_q <= match_d;
      count_q <= count_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, detector and registered-output decode
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    hist_d  = hist_q;
    hval_d  = hval_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    match_d = 1'b0;
    count_d = count_q;

    hist_sh  = (hist_q << 1) | PAT_W'(data_q[DATA_W-1]);
    hval_inc = (hval_q == LEN_W'(PAT_W)) ? hval_q : hval_q + LEN_W'(1);
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    // A zero effective length never matches
    hit = (len_q != '0) && (hval_inc >= len_q) &&
          (((hist_sh ^ pat_q) & len_mask) == '0);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          pat_d   = bus.cfg_pattern;
          len_d   = (bus.cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.cfg_len;
          ovl_d   = bus.cfg_overlap;
          hist_d  = '0;
          hval_d  = '0;
          count_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.in_valid && ready_q) begin
          data_d  = bus.in_data;
          last_d  = bus.in_last;
          bcnt_d  = BCNT_W'(DATA_W);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d = data_q << 1;
        hist_d = hist_sh;
        hval_d = hval_inc;
        bcnt_d = bcnt_q - BCNT_W'(1);
        if (hit) begin
          match_d = 1'b1;
          if (count_q != '1) count_d = count_q + CNT_W'(1);
          // Non-overlap: the next match must be built from fresh bits only
          if (!ovl_q) hval_d = '0;
        end
        if (bcnt_q == BCNT_W'(1)) begin
          state_d = last_q ? S_DONE : S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_WAIT);
    busy_d  = (state_d == S_WAIT) || (state_d == S_SHIFT);
    done_d  = (state_d == S_DONE);
  end

  assign bus.in_ready    = ready_q;
  assign bus.busy        = busy_q;
  assign bus.match_pulse = match_q;
  assign bus.match_count = count_q;
  assign bus.done        = done_q;
endmodule
